// File: rtl/alu_issue_scheduler.sv
// In-order issue controller for the fixed-latency ALU: RAW hazard stalls on in-flight
// destinations, register-file writeback generation ALU_LAT cycles after issue, and flush.
module alu_issue_scheduler #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_we,
    input  logic             flush,
    output logic             issue,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] rd;
    } stage_t;

    // stg[0] is the stage loaded at issue, stg[ALU_LAT-1] is the writeback stage
    stage_t [ALU_LAT-1:0] stg;
    stage_t [ALU_LAT-1:0] stg_nxt;
    stage_t               new_entry;
    stage_t               wb_stage;
    logic   [ALU_LAT-1:0] stage_valid;
    logic   [ALU_LAT-1:0] stage_hit;
    logic                 hazard;

    assign new_entry = {issue, in_we, in_rd};

    generate
        if (ALU_LAT == 1) begin : g_shift_single
            assign stg_nxt = new_entry;
        end else begin : g_shift_multi
            assign stg_nxt = {stg[ALU_LAT-2:0], new_entry};
        end
    endgenerate

    // The register file has no bypass, so the writeback stage is still a hazard.
    for (genvar k = 0; k < ALU_LAT; k++) begin : g_stage
        logic live;
        assign live           = stg[k].valid && stg[k].we && (stg[k].rd != 5'd0);
        assign stage_valid[k] = stg[k].valid;
        assign stage_hit[k]   = live &&
                                (((in_rs1 != 5'd0) && (in_rs1 == stg[k].rd)) ||
                                 ((in_rs2 != 5'd0) && (in_rs2 == stg[k].rd)));
    end

    assign hazard   = |stage_hit;
    assign in_ready = !flush && !hazard;
    assign issue    = in_valid && in_ready;
    assign busy     = |stage_valid;

    assign wb_stage = stg[ALU_LAT-1];
    assign wb_en    = wb_stage.valid && wb_stage.we && (wb_stage.rd != 5'd0);
    assign wb_rd    = wb_en ? wb_stage.rd : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg <= '0;
        end else if (flush) begin
            stg <= '0;
        end else begin
            stg <= stg_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && !in_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: independent stream, RAW stall, x0, flush,
// reset mid-flight and stall counter saturation (second instance with CNT_W=4).
module tb_alu_issue_scheduler;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        flush;

    logic        in_ready,   s_in_ready;
    logic        issue,      s_issue;
    logic        wb_en,      s_wb_en;
    logic [4:0]  wb_rd,      s_wb_rd;
    logic        busy,       s_busy;
    logic [15:0] stall_count;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    alu_issue_scheduler #(.ALU_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .flush(flush), .issue(issue), .wb_en(wb_en), .wb_rd(wb_rd),
        .busy(busy), .stall_count(stall_count)
    );

    alu_issue_scheduler #(.ALU_LAT(2), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .flush(flush), .issue(s_issue), .wb_en(s_wb_en), .wb_rd(s_wb_rd),
        .busy(s_busy), .stall_count(s_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic we);
        in_valid = v;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = rd;
        in_we    = we;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_count, 0);
        next_cycle();
        reset = 1'b0;

        // Independent stream: rd=1,2,3 issued back-to-back
        set_in(1'b1, 5'd4, 5'd5, 5'd1, 1'b1);
        @(negedge clk); chk("ind_issue0", issue, 1); chk("ind_wb0", wb_en, 0);
        next_cycle();
        set_in(1'b1, 5'd4, 5'd5, 5'd2, 1'b1);
        @(negedge clk); chk("ind_issue1", issue, 1); chk("ind_busy", busy, 1); chk("ind_wb1", wb_en, 0);
        next_cycle();
        set_in(1'b1, 5'd4, 5'd5, 5'd3, 1'b1);
        @(negedge clk); chk("ind_issue2", issue, 1); chk("ind_wben_a", wb_en, 1); chk("ind_wbrd_a", wb_rd, 1);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("ind_wben_b", wb_en, 1); chk("ind_wbrd_b", wb_rd, 2);
        next_cycle();
        @(negedge clk); chk("ind_wben_c", wb_en, 1); chk("ind_wbrd_c", wb_rd, 3);
        next_cycle();
        @(negedge clk);
        chk("ind_wben_end", wb_en, 0); chk("ind_wbrd_end", wb_rd, 0);
        chk("ind_busy_end", busy, 0); chk("ind_stall", stall_count, 0);

        // RAW on rs2: producer rd=5, consumer accepted three edges later
        apply_reset();
        set_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        @(negedge clk); chk("raw_prod_issue", issue, 1);
        next_cycle();
        set_in(1'b1, 5'd6, 5'd5, 5'd10, 1'b1);
        @(negedge clk); chk("raw_ready_1", in_ready, 0); chk("raw_issue_1", issue, 0);
        next_cycle();
        @(negedge clk); chk("raw_ready_2", in_ready, 0);
        chk("raw_wb_prod_en", wb_en, 1); chk("raw_wb_prod_rd", wb_rd, 5);
        next_cycle();
        @(negedge clk); chk("raw_ready_3", in_ready, 1); chk("raw_issue_3", issue, 1);
        chk("raw_stall", stall_count, 2);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("raw_wb_gap", wb_en, 0);
        next_cycle();
        @(negedge clk); chk("raw_wb_cons_en", wb_en, 1); chk("raw_wb_cons_rd", wb_rd, 10);
        chk("raw_stall_end", stall_count, 2);

        // x0 as destination and as source
        apply_reset();
        set_in(1'b1, 5'd1, 5'd2, 5'd0, 1'b1);
        @(negedge clk); chk("x0_prod_issue", issue, 1);
        next_cycle();
        set_in(1'b1, 5'd0, 5'd8, 5'd11, 1'b0);
        @(negedge clk); chk("x0_cons_issue", issue, 1);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("x0_wb_a", wb_en, 0); chk("x0_wbrd_a", wb_rd, 0);
        next_cycle();
        @(negedge clk); chk("x0_wb_b", wb_en, 0); chk("x0_stall", stall_count, 0);

        // Flush drops rd=7; dependent rs1=7 then issues without stall
        apply_reset();
        set_in(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        @(negedge clk); chk("fl_prod_issue", issue, 1);
        next_cycle();
        flush = 1'b1;
        set_in(1'b1, 5'd7, 5'd3, 5'd12, 1'b1);
        @(negedge clk); chk("fl_ready", in_ready, 0); chk("fl_issue", issue, 0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk); chk("fl_busy", busy, 0); chk("fl_wb", wb_en, 0);
        chk("fl_dep_issue", issue, 1); chk("fl_stall", stall_count, 1);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("fl_no_wb7", wb_en, 0);
        next_cycle();
        @(negedge clk); chk("fl_dep_wb_en", wb_en, 1); chk("fl_dep_wb_rd", wb_rd, 12);

        // Writeback already in its final cycle survives a flush
        apply_reset();
        set_in(1'b1, 5'd1, 5'd2, 5'd13, 1'b1);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        next_cycle();
        flush = 1'b1;
        @(negedge clk); chk("flwb_en", wb_en, 1); chk("flwb_rd", wb_rd, 13);
        next_cycle();
        flush = 1'b0;
        @(negedge clk); chk("flwb_after", wb_en, 0); chk("flwb_busy", busy, 0);

        // Reset mid-flight clears in-flight rd=9 and the stall count immediately
        apply_reset();
        flush = 1'b1;
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        next_cycle();
        flush = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
        next_cycle();
        chk("rmf_busy_pre", busy, 1); chk("rmf_stall_pre", stall_count, 1);
        reset = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rmf_busy", busy, 0); chk("rmf_stall", stall_count, 0); chk("rmf_wb", wb_en, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk); chk("rmf_wb_a", wb_en, 0); chk("rmf_busy_a", busy, 0);
        next_cycle();
        @(negedge clk); chk("rmf_wb_b", wb_en, 0);

        // Stall counter saturation: held flush with a pending instruction
        apply_reset();
        flush = 1'b1;
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        repeat (14) next_cycle();
        chk("sat_ready", s_in_ready, 0);
        chk("sat_14", s_stall_count, 14);
        next_cycle();
        chk("sat_15", s_stall_count, 15);
        repeat (5) next_cycle();
        chk("sat_hold", s_stall_count, 15);
        chk("sat_wide_20", stall_count, 20);
        flush = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
